// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency multiplier.
// Valid/ready: a requester holds req high with stable operands until its gnt pulse; done marks result.
module mult_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MULT_LAT = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start,
  input  logic [2*WIDTH-1:0] mul_prod,
  output logic [2:0]         fsm_state
);

  localparam int CW = (MULT_LAT < 2) ? 1 : $clog2(MULT_LAT);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               owner;
  logic               last;
  logic               winner;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] result_q;

  // A tie goes to whichever requester was not served by the last completed job.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = ~last;
    else if (req1)    winner = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      cnt      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= winner;
            mul_a <= winner ? a1 : a0;
            mul_b <= winner ? b1 : b0;
          end
        end
        START: cnt <= '0;
        WAIT:  cnt <= cnt + 1'b1;
        DONE: begin
          result_q <= mul_prod;
          last     <= owner;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    mul_start = 1'b0;
    result    = result_q;
    case (state)
      IDLE:  if (req0 || req1) state_nxt = LOAD;
      LOAD: begin
        gnt0      = ~owner;
        gnt1      = owner;
        state_nxt = START;
      end
      START: begin
        mul_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (cnt == CW'(MULT_LAT - 1)) state_nxt = DONE;
      DONE: begin
        // Forward the product so result is already valid during the done pulse.
        result    = mul_prod;
        done0     = ~owner;
        done1     = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural fixed-latency multiplier.
module tb_mult_arbiter;
  localparam int WIDTH    = 4;
  localparam int MULT_LAT = 5;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic               gnt0, gnt1, done0, done1, busy, mul_start;
  logic [2*WIDTH-1:0] result, mul_prod;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic [2:0]         fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start), .mul_prod(mul_prod), .fsm_state(fsm_state)
  );

  // Multiplier model: product is zeroed on start and appears MULT_LAT cycles later.
  int mdl_cnt = 0;
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mul_prod <= '0;
      mdl_cnt  <= MULT_LAT - 1;
    end else if (mdl_cnt == 1) begin
      mul_prod <= mul_a * mul_b;
      mdl_cnt  <= 0;
    end else if (mdl_cnt > 1) begin
      mdl_cnt <= mdl_cnt - 1;
    end
  end
  initial mul_prod = '0;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({gnt0, gnt1, done0, done1, mul_start, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000", {gnt0, gnt1, done0, done1, mul_start, busy});
    end
    n_checks++;
    if ({result, mul_a, mul_b} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0000", {result, mul_a, mul_b});
    end
  endtask

  task automatic test_single();
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd1;
    tick();
    n_checks++;
    if ({gnt0, gnt1, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL single_gnt: got %b expected 101", {gnt0, gnt1, busy});
    end
    req0 = 1'b0;
    tick();
    n_checks++;
    if ({mul_start, gnt0, mul_a, mul_b} !== {1'b1, 1'b0, 4'd2, 4'd1}) begin
      n_fail++;
      $display("FAIL single_start: got %b expected 1000100001", {mul_start, gnt0, mul_a, mul_b});
    end
    for (int i = 3; i < 8; i++) begin
      tick();
      n_checks++;
      if ({done0, mul_start, mul_a, mul_b} !== {2'b00, 4'd2, 4'd1}) begin
        n_fail++;
        $display("FAIL single_wait%0d: got %b expected 0000100001", i, {done0, mul_start, mul_a, mul_b});
      end
    end
    tick();
    n_checks++;
    if ({done0, done1, result} !== {2'b10, 8'd2}) begin
      n_fail++;
      $display("FAIL single_done: done0=%b done1=%b result=%0d expected 1 0 2", done0, done1, result);
    end
    tick();
    n_checks++;
    if ({done0, busy, result} !== {2'b00, 8'd2}) begin
      n_fail++;
      $display("FAIL single_after: done0=%b busy=%b result=%0d expected 0 0 2", done0, busy, result);
    end
  endtask

  task automatic test_tie();
    do_reset();
    req0 = 1'b1; a0 = 4'd4; b0 = 4'd3;
    req1 = 1'b1; a1 = 4'd15; b1 = 4'd15;
    tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL tie_first_gnt: got %b expected 10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    tick(7);
    n_checks++;
    if ({done0, done1, result} !== {2'b10, 8'd12}) begin
      n_fail++;
      $display("FAIL tie_done0: done0=%b done1=%b result=%0d expected 1 0 12", done0, done1, result);
    end
    tick();
    n_checks++;
    if ({gnt1, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL tie_idle: gnt1=%b busy=%b expected 0 0", gnt1, busy);
    end
    tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL tie_gnt1: got %b expected 01", {gnt0, gnt1});
    end
    req1 = 1'b0;
    tick(7);
    n_checks++;
    if ({done0, done1, result} !== {2'b01, 8'd225}) begin
      n_fail++;
      $display("FAIL tie_done1: done0=%b done1=%b result=%0d expected 0 1 225", done0, done1, result);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    logic [1:0] exp_d;
    logic [7:0] exp_r;
    tick();
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
    req1 = 1'b1; a1 = 4'd7; b1 = 4'd9;
    for (int t = 1; t <= 35; t++) begin
      tick();
      exp_g = 2'b00;
      exp_d = 2'b00;
      if (t % 9 == 1) exp_g = ((t / 9) % 2 == 0) ? 2'b10 : 2'b01;
      if (t % 9 == 8) exp_d = ((t / 9) % 2 == 0) ? 2'b10 : 2'b01;
      n_checks++;
      if ({gnt0, gnt1, done0, done1} !== {exp_g, exp_d}) begin
        n_fail++;
        $display("FAIL b2b_t%0d: gnt/done=%b expected %b", t, {gnt0, gnt1, done0, done1}, {exp_g, exp_d});
      end
      if (t % 9 == 8) begin
        exp_r = exp_d[1] ? 8'd15 : 8'd63;
        n_checks++;
        if (result !== exp_r) begin
          n_fail++;
          $display("FAIL b2b_result_t%0d: got %0d expected %0d", t, result, exp_r);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(2);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    int seen_done = 0;
    req0 = 1'b1; a0 = 4'd6; b0 = 4'd7;
    tick();
    req0 = 1'b0;
    tick(3);
    reset = 1'b0;
    tick();
    n_checks++;
    if ({busy, done0, done1} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_reset: busy/done=%b expected 000", {busy, done0, done1});
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done0 || done1 || busy) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: active cycles=%0d expected 0", seen_done);
    end
    req1 = 1'b1; a1 = 4'd0; b1 = 4'd9;
    tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_gnt1: got %b expected 01", {gnt0, gnt1});
    end
    req1 = 1'b0;
    tick(7);
    n_checks++;
    if ({done1, result} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL abort_done1: done1=%b result=%0d expected 1 0", done1, result);
    end
  endtask

  task automatic test_late_req();
    tick();
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd5;
    tick();
    req0 = 1'b0;
    tick(2);
    req1 = 1'b1; a1 = 4'd2; b1 = 4'd3;
    for (int t = 4; t <= 7; t++) begin
      tick();
      n_checks++;
      if (gnt1 !== 1'b0) begin
        n_fail++;
        $display("FAIL late_nogrant_t%0d: gnt1=%b expected 0", t, gnt1);
      end
    end
    tick();
    n_checks++;
    if ({done0, gnt1, result} !== {2'b10, 8'd25}) begin
      n_fail++;
      $display("FAIL late_done0: done0=%b gnt1=%b result=%0d expected 1 0 25", done0, gnt1, result);
    end
    tick(2);
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL late_gnt1: got %b expected 01", {gnt0, gnt1});
    end
    req1 = 1'b0;
    tick(7);
    n_checks++;
    if ({done1, result} !== {1'b1, 8'd6}) begin
      n_fail++;
      $display("FAIL late_done1: done1=%b result=%0d expected 1 6", done1, result);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_reset_abort();
    test_late_req();
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set operand width; product width is 2*WIDTH.
REQ-002 Parameter MULT_LAT, default 5, SHALL set the number of clk cycles from mul_start to a valid mul_prod.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-005 req0, req1  input  1 each  SHALL request a multiply; each is held high by its requester until its grant.
REQ-006 a0, b0, a1, b1  input  WIDTH each  SHALL carry each requester's operands, valid while its req is high.
REQ-007 gnt0, gnt1  output  1 each  SHALL pulse for one cycle when the operands of that requester are captured.
REQ-008 done0, done1  output  1 each  SHALL pulse for one cycle when result holds that requester's product.
REQ-009 result  output  2*WIDTH  SHALL hold the last completed product until the next done pulse.
REQ-010 busy  output  1  SHALL be high in every state except IDLE.
REQ-011 mul_a, mul_b  output  WIDTH each  SHALL drive the shared multiplier's operands.
REQ-012 mul_start  output  1  SHALL drive the shared multiplier's start input.
REQ-013 mul_prod  input  2*WIDTH  SHALL be the shared multiplier's product.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, START, WAIT and DONE.
REQ-015 IDLE -> LOAD when req0 or req1 is high; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: if both requests are high, grant the requester not served last; if only one is high, grant it.
REQ-017 LOAD SHALL assert the winner's gnt, register its a/b into mul_a/mul_b, record the owner, then go to START.
REQ-018 START SHALL assert mul_start for exactly one cycle with mul_a/mul_b stable, then go to WAIT.
REQ-019 WAIT SHALL last exactly MULT_LAT cycles, counted by an internal counter, then go to DONE.
REQ-020 DONE SHALL capture mul_prod into result, pulse the owner's done, update the last-served pointer to the owner, then go to IDLE.
REQ-021 For a request seen in IDLE in cycle N: gnt in N+1, mul_start in N+2, done in N+3+MULT_LAT (N+8 at the default).
REQ-022 mul_a/mul_b SHALL hold their values from LOAD through DONE, and mul_start SHALL be low outside START.
REQ-023 Requests arriving while busy SHALL NOT be granted and SHALL NOT be dropped; they are arbitrated at the next IDLE.
REQ-024 A requester that keeps req high after its done SHALL lose to a pending other requester, or be re-granted if it is alone.
REQ-025 gnt0/gnt1 SHALL never be high together, and neither SHALL be high at the same time as done0 or done1.
REQ-026 Products SHALL be unsigned, zero operands included; no overflow is possible at 2*WIDTH.

Reset
REQ-027 With reset low at a clk edge: state=IDLE; gnt*, done*, mul_start, busy = 0; result, mul_a, mul_b = 0; WAIT counter = 0; last-served pointer set so req0 wins the first tie.
REQ-028 Reset mid-operation SHALL abort the job with no done pulse, and the aborted requester SHALL have to re-request.

Verification
REQ-029 Reset: hold reset=0 for 2 cycles -> all outputs 0, busy=0.
REQ-030 Single request req0 with a0=2, b0=1, seen in cycle N -> gnt0 in N+1; mul_start in N+2 with mul_a=2, mul_b=1; done0 in N+8; result=2.
REQ-031 Tie after reset, req0 (4,3) and req1 (15,15) -> req0 is served first with result=12, then gnt1 comes 2 cycles after done0, with result=225 and done1.
REQ-032 Both requests held continuously for 4 jobs -> grants alternate 0,1,0,1, and each job takes 8 cycles plus 1 IDLE cycle.
REQ-033 Reset asserted during WAIT -> no done pulse, busy=0 the next cycle; a following req1 with a1=0, b1=9 -> done1 with result=0.
REQ-034 req1 raised while req0's job is in WAIT -> no gnt1 until that job's DONE, then gnt1 two cycles after done0.
